exec_core_p: RTL and testbench

Parametrised successor to the fixed 32-bit `processor` core: a multi-cycle fetch/execute controller with a configurable register file, a compare register and PC sequencing. Instructions arrive through a valid/ready handshake instead of being sampled blindly each cycle. `sys_dne` flags a halt, and `out` exposes the last written value. The block sits between the instruction source and the memory/address bus.

---
 rtl/exec_core_p.sv | 223 ++++++++++++++++++++++
 tb/tb_exec_core_p.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_core_p.sv
// exec_core_p: multi-cycle fetch/execute controller.
//
// An instruction is accepted through a valid/ready handshake in FETCH. The
// core then executes it in EXEC, and ADD/CMP take an extra write-back cycle
// (WB). HALT parks the core until reset.
//
// Parameters
//   DATA_W   : register, compare and out width (>= 16)
//   NREGS    : register count, power of two, 2..32
//   ADDR_W   : PC / addr width (>= 28)
//   RESET_PC : PC after reset (word aligned)
// Ports
//   clk, reset        : single rising-edge clock, synchronous active-high reset
//   instruction       : 32-bit instruction word, valid with instr_valid
//   instr_valid       : source offers an instruction
//   instr_ready       : core accepts (FETCH only)
//   out               : last value written to a register or emitted by OUT
//   addr              : current PC
//   rw                : one-cycle strobe after an OUT retires
//   sys_dne           : set when HALT executes, held until reset
module exec_core_p #(
  parameter int                DATA_W   = 32,
  parameter int                NREGS    = 8,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] out,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic              sys_dne
);

  localparam int         IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  localparam logic [5:0] OP_LDI  = 6'h0A;
  localparam logic [5:0] OP_ADD  = 6'h0B;
  localparam logic [5:0] OP_OUT  = 6'h0C;
  localparam logic [5:0] OP_JMP  = 6'h14;
  localparam logic [5:0] OP_CMP  = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h1B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

  state_t              state_reg, state_next;
  logic [31:0]         ir_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [DATA_W-1:0]   cmp_reg;
  logic [DATA_W-1:0]   out_reg;
  logic [DATA_W-1:0]   alu_reg;
  logic                rw_reg;
  logic                dne_reg;
  logic [DATA_W-1:0]   rf [NREGS];

  // Instruction fields (all decoded from the latched IR, never the live bus)
  logic [5:0]          op;
  logic [4:0]          rd_idx;
  logic [4:0]          rb_idx;
  logic [15:0]         imm16;
  logic [25:0]         tgt26;

  assign op     = ir_reg[31:26];
  assign rd_idx = ir_reg[25:21];
  assign rb_idx = ir_reg[20:16];
  assign imm16  = ir_reg[15:0];
  assign tgt26  = ir_reg[25:0];

  // Out-of-range indices read as zero and never get written.
  logic              rd_in_range, rb_in_range;
  logic [DATA_W-1:0] rd_val, rb_val;

  assign rd_in_range = ({1'b0, rd_idx} < NREGS_L);
  assign rb_in_range = ({1'b0, rb_idx} < NREGS_L);
  assign rd_val      = rd_in_range ? rf[rd_idx[IDX_W-1:0]] : '0;
  assign rb_val      = rb_in_range ? rf[rb_idx[IDX_W-1:0]] : '0;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_next;

  assign imm_ext  = DATA_W'(imm16);
  // CMP computes rb - ra; ADD computes rd + rb (ra and rd share a field).
  assign alu_next = (op == OP_CMP) ? (rb_val - rd_val) : (rd_val + rb_val);

  // PC sequencing candidates
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] beq_target;
  logic [ADDR_W-1:0] jmp_target;

  assign pc_plus4   = pc_reg + ADDR_W'(4);
  assign br_off     = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  assign beq_target = (cmp_reg == '0) ? (pc_plus4 + br_off) : pc_plus4;

  // JMP keeps the PC bits above bit 27; done bitwise so ADDR_W == 28 works.
  always_comb begin
    jmp_target       = pc_reg;
    jmp_target[27:0] = {tgt26, 2'b00};
  end

  // Register-file write port: LDI writes in EXEC, ADD writes in WB.
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_data = imm_ext;
    if (state_reg == S_EXEC && op == OP_LDI) begin
      wr_en = rd_in_range;
    end else if (state_reg == S_WB && op == OP_ADD) begin
      wr_en   = rd_in_range;
      wr_data = alu_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[rd_idx[IDX_W-1:0]] <= wr_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state and handshake
  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    case (state_reg)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_ADD || op == OP_CMP) begin
          state_next = S_WB;
        end else if (op == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_reg  <= '0;
      pc_reg  <= RESET_PC;
      cmp_reg <= '0;
      out_reg <= '0;
      alu_reg <= '0;
      rw_reg  <= 1'b0;
      dne_reg <= 1'b0;
    end else begin
      rw_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (instr_valid) begin
            ir_reg <= instruction;
          end
        end
        S_EXEC: begin
          case (op)
            OP_LDI: begin
              out_reg <= imm_ext;
              pc_reg  <= pc_plus4;
            end
            OP_ADD, OP_CMP: begin
              alu_reg <= alu_next;
            end
            OP_OUT: begin
              out_reg <= rd_val;
              rw_reg  <= 1'b1;
              pc_reg  <= pc_plus4;
            end
            OP_JMP:  pc_reg  <= jmp_target;
            OP_BEQ:  pc_reg  <= beq_target;
            OP_HALT: dne_reg <= 1'b1;
            default: pc_reg  <= pc_plus4;
          endcase
        end
        S_WB: begin
          if (op == OP_ADD) begin
            out_reg <= alu_reg;
          end else begin
            cmp_reg <= alu_reg;
          end
          pc_reg <= pc_plus4;
        end
        default: begin
        end
      endcase
    end
  end

  assign out     = out_reg;
  assign addr    = pc_reg;
  assign rw      = rw_reg;
  assign sys_dne = dne_reg;

endmodule

// File: tb/tb_exec_core_p.sv
// Bench for exec_core_p. Two instances run in lockstep on the same
// instruction stream: a 32-bit / 8-register core at RESET_PC 0 and a
// 16-bit / 4-register core at RESET_PC 0x200. An instruction-level model
// holds the architectural state of each and is compared every cycle.
module tb_exec_core_p;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;

  logic        ready_a, ready_b;
  logic [31:0] out_a;
  logic [15:0] out_b;
  logic [31:0] addr_a, addr_b;
  logic        rw_a, rw_b;
  logic        dne_a, dne_b;

  always #5 clk = ~clk;

  exec_core_p #(.DATA_W(32), .NREGS(8), .ADDR_W(32), .RESET_PC(32'h0)) u_dut_a (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(ready_a), .out(out_a), .addr(addr_a), .rw(rw_a), .sys_dne(dne_a)
  );

  exec_core_p #(.DATA_W(16), .NREGS(4), .ADDR_W(32), .RESET_PC(32'h200)) u_dut_b (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(ready_b), .out(out_b), .addr(addr_b), .rw(rw_b), .sys_dne(dne_b)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Per-instance model parameters
  logic [31:0] msk   [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  int          nr    [2] = '{8, 4};
  logic [31:0] rstpc [2] = '{32'h0, 32'h200};

  // Architectural model state
  logic [31:0] m_r   [2][32];
  logic [31:0] m_cmp [2];
  logic [31:0] m_out [2];
  logic [31:0] m_pc  [2];
  logic        exp_rw, exp_ready, exp_dne;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rreg(input int k, input logic [4:0] i);
    return (int'(i) < nr[k]) ? m_r[k][i] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m_r[k][i] = 32'h0;
      m_cmp[k] = 32'h0;
      m_out[k] = 32'h0;
      m_pc[k]  = rstpc[k];
    end
    exp_rw    = 1'b0;
    exp_ready = 1'b1;
    exp_dne   = 1'b0;
  endtask

  // Applies one retired instruction to the architectural model.
  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  op;
    logic [4:0]  rd, rb;
    logic [31:0] v, off;
    op  = ins[31:26];
    rd  = ins[25:21];
    rb  = ins[20:16];
    off = {{14{ins[15]}}, ins[15:0], 2'b00};
    for (int k = 0; k < 2; k++) begin
      case (op)
        6'h0A: begin
          v = {16'h0, ins[15:0]} & msk[k];
          if (int'(rd) < nr[k]) m_r[k][rd] = v;
          m_out[k] = v;
          m_pc[k]  = m_pc[k] + 4;
        end
        6'h0B: begin
          v = (rreg(k, rd) + rreg(k, rb)) & msk[k];
          if (int'(rd) < nr[k]) m_r[k][rd] = v;
          m_out[k] = v;
          m_pc[k]  = m_pc[k] + 4;
        end
        6'h0C: begin
          m_out[k] = rreg(k, rd);
          exp_rw   = 1'b1;
          m_pc[k]  = m_pc[k] + 4;
        end
        6'h14: m_pc[k] = {m_pc[k][31:28], ins[25:0], 2'b00};
        6'h15: begin
          m_cmp[k] = (rreg(k, rb) - rreg(k, rd)) & msk[k];
          m_pc[k]  = m_pc[k] + 4;
        end
        6'h1B: m_pc[k] = (m_cmp[k] == 32'h0) ? (m_pc[k] + 4 + off) : (m_pc[k] + 4);
        6'h3F: exp_dne = 1'b1;
        default: m_pc[k] = m_pc[k] + 4;
      endcase
    end
    exp_ready = (op != 6'h3F);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr_a",  addr_a,           m_pc[0]);
      chk("out_a",   out_a,            m_out[0]);
      chk("rw_a",    {31'h0, rw_a},    {31'h0, exp_rw});
      chk("dne_a",   {31'h0, dne_a},   {31'h0, exp_dne});
      chk("ready_a", {31'h0, ready_a}, {31'h0, exp_ready});
      chk("addr_b",  addr_b,           m_pc[1]);
      chk("out_b",   {16'h0, out_b},   m_out[1]);
      chk("rw_b",    {31'h0, rw_b},    {31'h0, exp_rw});
      chk("dne_b",   {31'h0, dne_b},   {31'h0, exp_dne});
      chk("ready_b", {31'h0, ready_b}, {31'h0, exp_ready});
    end
  end

  // Advance one edge; rw is a single-cycle strobe so the model drops it here.
  task automatic tick();
    @(posedge clk);
    #1;
    exp_rw = 1'b0;
  endtask

  // Presents one instruction, accepts it, scrambles the bus while the core
  // is busy, and updates the model on the retire edge.
  task automatic exec_instr(input logic [31:0] ins);
    int lat;
    lat = (ins[31:26] == 6'h0B || ins[31:26] == 6'h15) ? 3 : 2;
    instruction = ins;
    instr_valid = 1'b1;
    tick();
    exp_ready = 1'b0;
    for (int e = 1; e < lat; e++) begin
      instruction = $urandom;
      instr_valid = 1'($urandom);
      tick();
    end
    model_exec(ins);
    instr_valid = 1'b0;
    $display("instr %h addr_a=%h out_a=%h addr_b=%h out_b=%h", ins, addr_a, out_a, addr_b, out_b);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      instruction = $urandom;
      tick();
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    tick();
    model_reset();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rb;
    logic [15:0] imm;
    rd  = 5'($urandom_range(0, 9));
    rb  = 5'($urandom_range(0, 9));
    imm = 16'($urandom);
    case ($urandom_range(0, 7))
      0, 1: return {6'h0A, rd, 5'h0, imm};
      2:    return {6'h0B, rd, rb, 16'h0};
      3:    return {6'h0C, rd, 5'h0, 16'h0};
      4:    return {6'h15, rd, rb, 16'h0};
      5:    return {6'h1B, 10'h0, 16'($signed(32'($urandom_range(0, 15)) - 8))};
      6:    return {6'h14, 26'($urandom)};
      default: return {6'h01, 26'($urandom)};
    endcase
  endfunction

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instruction = 32'h0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_addr",  addr_a, 32'h0);
    chk("rst_out",   out_a,  32'h0);
    chk("rst_ready", {31'h0, ready_a}, 32'h1);
    chk("rst_addr_b", addr_b, 32'h200);

    // Load sequence
    exec_instr(32'h2820002B);
    exec_instr(32'h28400020);
    exec_instr(32'h28600000);
    exec_instr(32'h28800003);
    chk("load_addr", addr_a, 32'h10);
    chk("load_out",  out_a,  32'h3);
    exec_instr(32'h30200000);
    chk("load_r1", out_a, 32'h2B);

    // Jump, compare, branch not taken
    exec_instr(32'h50EB347A);
    chk("jmp_addr", addr_a, 32'h03ACD1E8);
    exec_instr(32'h54830000);
    chk("cmp_addr", addr_a, 32'h03ACD1EC);
    exec_instr(32'h6FFB0932);
    chk("beq_nt_addr", addr_a, 32'h03ACD1F0);

    // Branch taken backward from 0x100
    exec_instr(32'h5000003F);
    exec_instr(32'h54210000);
    chk("beq_pc_before", addr_a, 32'h100);
    exec_instr(32'h6C00FFFE);
    chk("beq_taken_addr", addr_a, 32'hFC);

    // Stall with the bus idle
    idle(5);

    // Width and register-count boundaries
    exec_instr(32'h2820FFFF);
    exec_instr(32'h2C210000);
    chk("add_ovf_b", {16'h0, out_b}, 32'hFFFE);
    chk("add_ovf_a", out_a, 32'h1FFFE);
    exec_instr(32'h28E00005);
    chk("ldi_r7_out_b", {16'h0, out_b}, 32'h5);
    exec_instr(32'h30E00000);
    chk("out_r7_b", {16'h0, out_b}, 32'h0);
    chk("out_r7_a", out_a, 32'h5);

    // Randomized traffic with occasional idle gaps
    for (int n = 0; n < 200; n++) begin
      exec_instr(rand_instr());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Halt, then keep offering instructions
    exec_instr(32'hFC000000);
    chk("halt_dne",   {31'h0, dne_a},   32'h1);
    chk("halt_ready", {31'h0, ready_a}, 32'h0);
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruction = 32'h2C210000;
      tick();
    end
    do_reset();
    chk("post_halt_dne", {31'h0, dne_a}, 32'h0);

    // Reset landing on an in-flight ADD
    exec_instr(32'h28400007);
    instruction = 32'h2C420000;
    instr_valid = 1'b1;
    tick();
    exp_ready   = 1'b0;
    instr_valid = 1'b0;
    do_reset();
    chk("midadd_addr", addr_a, 32'h0);
    chk("midadd_out",  out_a,  32'h0);
    exec_instr(32'h30400000);
    chk("midadd_r2", out_a, 32'h0);
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
